// File: rtl/mul_seq_ctrl.sv
// Sequential unsigned shift-add multiplier controller. It steps an external WIDTH-bit adder
// through one partial product per cycle and exposes a start/busy/done handshake.
module mul_seq_ctrl #(
   parameter int unsigned WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic [WIDTH-1:0]   add_a,
   output logic [WIDTH-1:0]   add_b,
   output logic               add_ci,
   input  logic [WIDTH-1:0]   add_o,
   input  logic               add_co
);

   localparam int unsigned CNT_W  = $clog2(WIDTH) + 1;
   localparam int unsigned PROD_W = 2 * WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_q,   state_d;
   logic [WIDTH-1:0]    mcand_q,   mcand_d;
   logic [WIDTH-1:0]    p_hi_q,    p_hi_d;
   logic [WIDTH-1:0]    p_lo_q,    p_lo_d;
   logic [CNT_W-1:0]    count_q,   count_d;
   logic [PROD_W-1:0]   product_q, product_d;
   logic                busy_q,    busy_d;
   logic                done_q,    done_d;
   logic [WIDTH-1:0]    add_a_q,   add_a_d;
   logic [WIDTH-1:0]    add_b_q,   add_b_d;

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      p_hi_d    = p_hi_q;
      p_lo_d    = p_lo_q;
      count_d   = count_q;
      product_d = product_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               mcand_d = op_a;
               p_lo_d  = op_b;
               p_hi_d  = '0;
               count_d = '0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            // The adder carry becomes the new MSB so the 17th sum bit is never lost
            p_hi_d  = {add_co, add_o[WIDTH-1:1]};
            p_lo_d  = {add_o[0], p_lo_q[WIDTH-1:1]};
            count_d = count_q + CNT_W'(1);
            if (count_q == CNT_W'(WIDTH - 1)) begin
               product_d = {p_hi_d, p_lo_d};
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Adder operands are precomputed for the coming cycle; zero outside CALC keeps the adder quiet
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
      add_a_d = (state_d == S_CALC) ? p_hi_d : '0;
      add_b_d = ((state_d == S_CALC) && p_lo_d[0]) ? mcand_d : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         mcand_q   <= '0;
         p_hi_q    <= '0;
         p_lo_q    <= '0;
         count_q   <= '0;
         product_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         add_a_q   <= '0;
         add_b_q   <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         p_hi_q    <= p_hi_d;
         p_lo_q    <= p_lo_d;
         count_q   <= count_d;
         product_q <= product_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         add_a_q   <= add_a_d;
         add_b_q   <= add_b_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;
   assign add_a   = add_a_q;
   assign add_b   = add_b_q;
   assign add_ci  = 1'b0;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: a behavioural adder closes the loop, a cycle-level reference model
// feeds a scoreboard, and a monitor checks every cycle and every done pulse.
module tb_mul_seq_ctrl;

   localparam int unsigned W = 16;

   logic           clk;
   logic           rst;
   logic           start;
   logic [W-1:0]   op_a;
   logic [W-1:0]   op_b;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;
   logic [W-1:0]   add_a;
   logic [W-1:0]   add_b;
   logic           add_ci;
   logic [W-1:0]   add_o;
   logic           add_co;

   mul_seq_ctrl #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op_a    (op_a),
      .op_b    (op_b),
      .busy    (busy),
      .done    (done),
      .product (product),
      .add_a   (add_a),
      .add_b   (add_b),
      .add_ci  (add_ci),
      .add_o   (add_o),
      .add_co  (add_co)
   );

   // Downstream ripple adder, behaviourally
   always_comb begin
      {add_co, add_o} = (W+1)'(add_a) + (W+1)'(add_b) + (W+1)'(add_ci);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit checking = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: an accepted op occupies W compute cycles plus one done cycle
   logic [31:0] exp_q[$];
   bit          in_op  = 1'b0;
   int          k      = 0;
   logic [W-1:0] cur_a = '0;
   logic [W-1:0] cur_b = '0;
   logic [31:0]  prod_m = '0;
   int          n_acc  = 0;

   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            in_op  = 1'b0;
            k      = 0;
            prod_m = '0;
            exp_q.delete();
         end else if (!in_op) begin
            if (start) begin
               in_op = 1'b1;
               k     = 1;
               cur_a = op_a;
               cur_b = op_b;
               exp_q.push_back(32'(op_a) * 32'(op_b));
               n_acc++;
            end
         end else if (k == W + 1) begin
            in_op = 1'b0;
         end else begin
            k++;
            if (k == W + 1) prod_m = 32'(cur_a) * 32'(cur_b);
         end
      end
   end

   // Monitor: per-cycle interface check plus scoreboard pop on each done pulse
   initial begin
      forever begin
         @(negedge clk);
         if (checking) begin
            bit           exp_calc;
            logic [W-1:0] ea;
            logic [W-1:0] eb;
            exp_calc = in_op && (k <= W);
            ea = '0;
            eb = '0;
            if (exp_calc) begin
               int j;
               logic [31:0] mask;
               j    = k - 1;
               mask = (32'd1 << j) - 32'd1;
               ea   = W'((32'(cur_a) * (32'(cur_b) & mask)) >> j);
               eb   = cur_b[j] ? cur_a : '0;
            end
            check("busy",    64'(busy),    64'(in_op));
            check("done",    64'(done),    64'(in_op && (k == W + 1)));
            check("product", 64'(product), 64'(prod_m));
            check("add_a",   64'(add_a),   64'(ea));
            check("add_b",   64'(add_b),   64'(eb));
            check("add_ci",  64'(add_ci),  64'(0));
            if (done) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_done", 64'(1), 64'(0));
               end else begin
                  logic [31:0] e;
                  e = exp_q.pop_front();
                  check("sb_product", 64'(product), 64'(e));
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Start in this cycle, end in the first IDLE cycle after done
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [31:0] want);
      start = 1'b1;
      op_a  = a;
      op_b  = b;
      step();
      start = 1'b0;
      op_a  = W'($urandom);
      op_b  = W'($urandom);
      repeat (W) step();
      check("dir_done",    64'(done),    64'(1));
      check("dir_product", 64'(product), 64'(want));
      step();
   endtask

   initial begin
      int guard;
      int target;
      rst   = 1'b1;
      start = 1'b0;
      op_a  = '0;
      op_b  = '0;
      repeat (3) step();
      rst = 1'b0;
      checking = 1'b1;
      check("rst_busy",    64'(busy),    64'(0));
      check("rst_product", 64'(product), 64'(0));
      step();

      run_op(16'd3, 16'd5, 32'h0000_000F);
      run_op(16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
      run_op(16'h1234, 16'h0000, 32'h0);
      run_op(16'h0000, 16'hBEEF, 32'h0);

      // Start while computing is ignored; start right after done is accepted
      start = 1'b1; op_a = 16'd7; op_b = 16'd9;
      step();
      start = 1'b0;
      repeat (4) step();
      start = 1'b1; op_a = 16'd2; op_b = 16'd2;
      step();
      start = 1'b0;
      repeat (11) step();
      check("ignore_done",    64'(done),    64'(1));
      check("ignore_product", 64'(product), 64'(32'h3F));
      step();
      run_op(16'd2, 16'd2, 32'd4);

      // Abort mid-computation
      start = 1'b1; op_a = 16'h00FF; op_b = 16'h0101;
      step();
      start = 1'b0;
      repeat (7) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_busy",    64'(busy),    64'(0));
      check("abort_product", 64'(product), 64'(0));
      repeat (W + 2) begin
         check("abort_no_done", 64'(done), 64'(0));
         step();
      end

      // Reset beats start
      rst = 1'b1; start = 1'b1; op_a = 16'd5; op_b = 16'd5;
      step();
      rst = 1'b0; start = 1'b0;
      check("rst_start_busy", 64'(busy), 64'(0));
      step();

      // Random traffic with stray starts, changing operands and rare resets
      target = n_acc + 1000;
      guard  = 0;
      while (n_acc < target && guard < 40000) begin
         start = ($urandom_range(0, 3) == 0);
         op_a  = W'($urandom);
         op_b  = W'($urandom);
         if ($urandom_range(0, 7) == 0) op_a = ($urandom_range(0, 1) != 0) ? '1 : '0;
         if ($urandom_range(0, 7) == 0) op_b = ($urandom_range(0, 1) != 0) ? '1 : '0;
         rst   = ($urandom_range(0, 499) == 0);
         step();
         guard++;
      end
      check("random_budget", 64'(n_acc >= target), 64'(1));
      rst   = 1'b0;
      start = 1'b0;
      repeat (W + 3) step();
      check("drain", 64'(exp_q.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
